// File: rtl/vram_wr_sched_pkg.sv
// Shared types and constants for the VRAM write scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default queue depth / address width, FSM state encoding and a
// ceil-log2 helper used to size pointers and the occupancy counter.
package vram_wr_sched_pkg;

    localparam int C_DEPTH_DEF = 4;
    localparam int C_AW_DEF    = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // queue empty
        S_WAIT  = 2'd1,   // entries pending, write window closed
        S_DRAIN = 2'd2    // entries pending, window open: pop one per cycle
    } state_t;

    // ceil(log2(v)) for v >= 1; constant-foldable at elaboration.
    function automatic int f_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vram_wr_sched_if.sv
// CPU-side write request bus and VRAM-side write port of the scheduler.
// Latency: n/a (wiring only).
// Backpressure: none on the request side; overflow is flagged, not stalled.
//
// slave  : the scheduler (consumes CPU/window inputs, drives VRAM port + status)
// master : the CPU/video side that drives requests and observes status
interface vram_wr_sched_if #(
    parameter int C_AW    = vram_wr_sched_pkg::C_AW_DEF,
    parameter int C_DEPTH = vram_wr_sched_pkg::C_DEPTH_DEF
);
    localparam int LW = vram_wr_sched_pkg::f_log2(C_DEPTH) + 1;

    logic [7:0]      CPU_VRAM_WDs_i;
    logic [C_AW-1:0] CPU_VRAM_WAs_i;
    logic            CPU_VRAM_WE_i;
    logic            CPU_USE_i;
    logic            BLANK_i;
    logic            OVF_CLR_i;

    logic [7:0]      VRAM_WDs_o;
    logic [C_AW-1:0] VRAM_WAs_o;
    logic            VRAM_WE_o;
    logic [LW-1:0]   LEVELs_o;
    logic            BUSY_o;
    logic            OVF_o;

    modport slave (
        input  CPU_VRAM_WDs_i, CPU_VRAM_WAs_i, CPU_VRAM_WE_i,
        input  CPU_USE_i, BLANK_i, OVF_CLR_i,
        output VRAM_WDs_o, VRAM_WAs_o, VRAM_WE_o,
        output LEVELs_o, BUSY_o, OVF_o
    );

    modport master (
        output CPU_VRAM_WDs_i, CPU_VRAM_WAs_i, CPU_VRAM_WE_i,
        output CPU_USE_i, BLANK_i, OVF_CLR_i,
        input  VRAM_WDs_o, VRAM_WAs_o, VRAM_WE_o,
        input  LEVELs_o, BUSY_o, OVF_o
    );

endinterface

// File: rtl/vram_wr_sched_fifo.sv
// Circular write queue: storage, read/write pointers and occupancy count.
// Latency: push visible at pop_dat one cycle later (no same-cycle bypass).
// Backpressure: push while full without a pop is dropped and flagged on drop.
//
// Ports: clk/rst, push/push_dat, pop -> pop_dat (head entry, combinational),
// empty, level (registered occupancy), level_nxt (occupancy after this edge),
// drop (push rejected this cycle).
module vram_wr_sched_fifo
    import vram_wr_sched_pkg::*;
#(
    parameter int C_DEPTH = C_DEPTH_DEF,
    parameter int C_DW    = C_AW_DEF + 8,
    localparam int PW     = f_log2(C_DEPTH),
    localparam int LW     = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [C_DW-1:0] push_dat,
    input  logic            pop,
    output logic [C_DW-1:0] pop_dat,
    output logic            empty,
    output logic [LW-1:0]   level,
    output logic [LW-1:0]   level_nxt,
    output logic            drop
);

    logic [C_DW-1:0] mem [C_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   level_q;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (level_q == LW'(C_DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & ~push_ok;
    assign pop_dat = mem[rd_ptr];
    assign level   = level_q;

    always_comb begin
        level_nxt = level_q;
        if (push_ok && !pop_ok) begin
            level_nxt = level_q + LW'(1);
        end else if (!push_ok && pop_ok) begin
            level_nxt = level_q - LW'(1);
        end
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level_q <= level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/vram_wr_sched.sv
// Queues CPU VRAM writes and replays them only inside the write window.
// Latency: request to VRAM_WE_o is 2 cycles with an open window and empty queue.
// Backpressure: none; requests into a full queue are dropped and OVF_o is set.
//
// Ports: CK_i clock, SYS_R_i async active-high reset, bus (slave modport):
// CPU request (WE level, address, data), window inputs BLANK_i/CPU_USE_i,
// OVF_CLR_i; VRAM write port, LEVELs_o occupancy, BUSY_o, sticky OVF_o.
module vram_wr_sched
    import vram_wr_sched_pkg::*;
#(
    parameter int C_DEPTH = C_DEPTH_DEF,
    parameter int C_AW    = C_AW_DEF
) (
    input  logic           CK_i,
    input  logic           SYS_R_i,
    vram_wr_sched_if.slave bus
);

    localparam int LW = f_log2(C_DEPTH) + 1;
    localparam int DW = C_AW + 8;

    logic            we_q;
    logic            wr_req;
    logic            win;
    state_t          state_q;
    state_t          state_d;
    logic            pop;
    logic            pop_fire;
    logic [DW-1:0]   pop_dat;
    logic            fifo_empty;
    logic            fifo_drop;
    logic [LW-1:0]   level;
    logic [LW-1:0]   level_nxt;
    logic            vram_we_q;
    logic [C_AW-1:0] vram_wa_q;
    logic [7:0]      vram_wd_q;
    logic            busy_q;
    logic            ovf_q;

    // History resets to 1 so a WE level already high at reset release is
    // not mistaken for a fresh request.
    always_ff @(posedge CK_i or posedge SYS_R_i) begin
        if (SYS_R_i) begin
            we_q <= 1'b1;
        end else begin
            we_q <= bus.CPU_VRAM_WE_i;
        end
    end

    assign wr_req   = bus.CPU_VRAM_WE_i & ~we_q;
    assign win      = bus.BLANK_i | bus.CPU_USE_i;
    assign pop_fire = pop & ~fifo_empty;

    vram_wr_sched_fifo #(
        .C_DEPTH (C_DEPTH),
        .C_DW    (DW)
    ) u_fifo (
        .clk       (CK_i),
        .rst       (SYS_R_i),
        .push      (wr_req),
        .push_dat  ({bus.CPU_VRAM_WAs_i, bus.CPU_VRAM_WDs_i}),
        .pop       (pop_fire),
        .pop_dat   (pop_dat),
        .empty     (fifo_empty),
        .level     (level),
        .level_nxt (level_nxt),
        .drop      (fifo_drop)
    );

    always_ff @(posedge CK_i or posedge SYS_R_i) begin
        if (SYS_R_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // State follows the post-edge occupancy and this cycle's window, so a
    // window closing in cycle k still allows the pop already scheduled for k
    // and stops draining from k+1. A fresh push is only seen by the state
    // register after the edge, which rules out same-cycle bypass.
    always_comb begin
        state_d = S_IDLE;
        if (level_nxt != '0) begin
            state_d = win ? S_DRAIN : S_WAIT;
        end
    end

    // Pop decode kept apart from next-state logic: level_nxt depends on pop.
    assign pop = (state_q == S_DRAIN);

    always_ff @(posedge CK_i or posedge SYS_R_i) begin
        if (SYS_R_i) begin
            vram_we_q <= 1'b0;
            vram_wa_q <= '0;
            vram_wd_q <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            vram_we_q <= pop_fire;
            if (pop_fire) begin
                {vram_wa_q, vram_wd_q} <= pop_dat;
            end
            busy_q <= (level_nxt != '0);
            // New overflow beats a simultaneous clear.
            if (fifo_drop) begin
                ovf_q <= 1'b1;
            end else if (bus.OVF_CLR_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.VRAM_WE_o  = vram_we_q;
    assign bus.VRAM_WAs_o = vram_wa_q;
    assign bus.VRAM_WDs_o = vram_wd_q;
    assign bus.LEVELs_o   = level;
    assign bus.BUSY_o     = busy_q;
    assign bus.OVF_o      = ovf_q;

endmodule

// File: tb/tb_vram_wr_sched.sv
module tb_vram_wr_sched;

    logic CK_i;
    logic SYS_R_i;
    int   cyc;
    int   n_chk;
    int   n_fail;

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t sb[$];

    vram_wr_sched_if #(.C_AW(10), .C_DEPTH(4)) bus ();

    vram_wr_sched #(.C_DEPTH(4), .C_AW(10)) dut (
        .CK_i    (CK_i),
        .SYS_R_i (SYS_R_i),
        .bus     (bus)
    );

    initial CK_i = 1'b0;
    always #5 CK_i = ~CK_i;

    initial cyc = 0;
    always @(posedge CK_i) cyc <= cyc + 1;

    task automatic tick();
        @(posedge CK_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic req(input logic [9:0] a, input logic [7:0] d);
        bus.CPU_VRAM_WAs_i = a;
        bus.CPU_VRAM_WDs_i = d;
        bus.CPU_VRAM_WE_i  = 1'b1;
        tick();
        bus.CPU_VRAM_WE_i  = 1'b0;
        tick();
    endtask

    task automatic expect_wr(input logic [9:0] a, input logic [7:0] d, input int c);
        exp_t e;
        e.a = a;
        e.d = d;
        e.c = c;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    32'(bus.VRAM_WE_o),  32'd0);
        chk({tag, "_wa"},    32'(bus.VRAM_WAs_o), 32'd0);
        chk({tag, "_wd"},    32'(bus.VRAM_WDs_o), 32'd0);
        chk({tag, "_level"}, 32'(bus.LEVELs_o),   32'd0);
        chk({tag, "_busy"},  32'(bus.BUSY_o),     32'd0);
        chk({tag, "_ovf"},   32'(bus.OVF_o),      32'd0);
    endtask

    // Monitor: every VRAM write pulse must match the oldest expected entry.
    always @(negedge CK_i) begin
        if (!SYS_R_i && bus.VRAM_WE_o === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got 0x%0h/0x%0h expected no write (cycle %0d)",
                         bus.VRAM_WAs_o, bus.VRAM_WDs_o, cyc);
            end else begin
                e = sb.pop_front();
                chk("wr_addr_data", {14'd0, bus.VRAM_WAs_o, bus.VRAM_WDs_o}, {14'd0, e.a, e.d});
                if (e.c >= 0) begin
                    chk("wr_cycle", 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        n_chk  = 0;
        n_fail = 0;
        SYS_R_i            = 1'b1;
        bus.CPU_VRAM_WDs_i = '0;
        bus.CPU_VRAM_WAs_i = '0;
        bus.CPU_VRAM_WE_i  = 1'b0;
        bus.CPU_USE_i      = 1'b0;
        bus.BLANK_i        = 1'b0;
        bus.OVF_CLR_i      = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        SYS_R_i = 1'b0;

        // Single write with the window open: pulse exactly two cycles later.
        bus.BLANK_i = 1'b1;
        while (cyc < 10) tick();
        bus.CPU_VRAM_WAs_i = 10'h123;
        bus.CPU_VRAM_WDs_i = 8'h5A;
        bus.CPU_VRAM_WE_i  = 1'b1;
        expect_wr(10'h123, 8'h5A, cyc + 2);
        tick();
        chk("single_level", 32'(bus.LEVELs_o), 32'd1);
        chk("single_busy",  32'(bus.BUSY_o),   32'd1);
        bus.CPU_VRAM_WE_i = 1'b0;
        repeat (3) tick();
        chk("single_level_end", 32'(bus.LEVELs_o),   32'd0);
        chk("single_busy_end",  32'(bus.BUSY_o),     32'd0);
        chk("single_wa_hold",   32'(bus.VRAM_WAs_o), 32'h123);
        chk("single_wd_hold",   32'(bus.VRAM_WDs_o), 32'h5A);

        // Window closed: three requests wait, then drain back-to-back.
        bus.BLANK_i = 1'b0;
        req(10'h001, 8'h11);
        req(10'h002, 8'h22);
        req(10'h003, 8'h33);
        chk("held_level", 32'(bus.LEVELs_o), 32'd3);
        chk("held_busy",  32'(bus.BUSY_o),   32'd1);
        bus.BLANK_i = 1'b1;
        b = cyc;
        expect_wr(10'h001, 8'h11, b + 2);
        expect_wr(10'h002, 8'h22, b + 3);
        expect_wr(10'h003, 8'h33, b + 4);
        repeat (6) tick();
        chk("held_level_end", 32'(bus.LEVELs_o), 32'd0);
        chk("held_busy_end",  32'(bus.BUSY_o),   32'd0);

        // Overflow: fifth request dropped, flag sticky until cleared.
        bus.BLANK_i = 1'b0;
        for (int i = 0; i < 4; i++) req(10'(16 + i), 8'(8'hA0 + i));
        chk("ovf_level_full", 32'(bus.LEVELs_o), 32'd4);
        chk("ovf_before",     32'(bus.OVF_o),    32'd0);
        req(10'h014, 8'hA4);
        chk("ovf_set",        32'(bus.OVF_o),    32'd1);
        chk("ovf_level_kept", 32'(bus.LEVELs_o), 32'd4);
        bus.BLANK_i = 1'b1;
        b = cyc;
        for (int i = 0; i < 4; i++) expect_wr(10'(16 + i), 8'(8'hA0 + i), b + 2 + i);
        repeat (7) tick();
        chk("ovf_level_end", 32'(bus.LEVELs_o), 32'd0);
        chk("ovf_sticky",    32'(bus.OVF_o),    32'd1);
        bus.BLANK_i   = 1'b0;
        bus.OVF_CLR_i = 1'b1;
        tick();
        bus.OVF_CLR_i = 1'b0;
        chk("ovf_cleared", 32'(bus.OVF_o), 32'd0);

        // Window chop: two cycles of blank give exactly two writes.
        for (int i = 0; i < 4; i++) req(10'(32 + i), 8'(8'hB0 + i));
        bus.BLANK_i = 1'b1;
        b = cyc;
        expect_wr(10'h020, 8'hB0, b + 2);
        expect_wr(10'h021, 8'hB1, b + 3);
        repeat (2) tick();
        bus.BLANK_i = 1'b0;
        repeat (4) tick();
        chk("chop_level_mid", 32'(bus.LEVELs_o), 32'd2);
        bus.BLANK_i = 1'b1;
        b = cyc;
        expect_wr(10'h022, 8'hB2, b + 2);
        expect_wr(10'h023, 8'hB3, b + 3);
        repeat (5) tick();
        bus.BLANK_i = 1'b0;
        chk("chop_level_end", 32'(bus.LEVELs_o), 32'd0);

        // Full queue with simultaneous push and pop: accepted, no overflow.
        for (int i = 0; i < 4; i++) req(10'(48 + i), 8'(8'hC0 + i));
        chk("fpp_level_full", 32'(bus.LEVELs_o), 32'd4);
        bus.BLANK_i = 1'b1;
        b = cyc;
        for (int i = 0; i < 5; i++) expect_wr(10'(48 + i), 8'(8'hC0 + i), b + 2 + i);
        tick();
        bus.CPU_VRAM_WAs_i = 10'h034;
        bus.CPU_VRAM_WDs_i = 8'hC4;
        bus.CPU_VRAM_WE_i  = 1'b1;
        tick();
        chk("fpp_level_kept", 32'(bus.LEVELs_o), 32'd4);
        chk("fpp_no_ovf",     32'(bus.OVF_o),    32'd0);
        bus.CPU_VRAM_WE_i = 1'b0;
        repeat (6) tick();
        chk("fpp_level_end", 32'(bus.LEVELs_o), 32'd0);
        bus.BLANK_i = 1'b0;

        // Overflow beats a simultaneous clear, then reset mid-drain.
        for (int i = 0; i < 4; i++) req(10'(64 + i), 8'(8'hD0 + i));
        req(10'h044, 8'hD4);
        bus.OVF_CLR_i      = 1'b1;
        bus.CPU_VRAM_WAs_i = 10'h045;
        bus.CPU_VRAM_WDs_i = 8'hD5;
        bus.CPU_VRAM_WE_i  = 1'b1;
        tick();
        bus.OVF_CLR_i     = 1'b0;
        bus.CPU_VRAM_WE_i = 1'b0;
        chk("ovf_beats_clr", 32'(bus.OVF_o), 32'd1);
        tick();
        bus.BLANK_i = 1'b1;
        b = cyc;
        expect_wr(10'h040, 8'hD0, b + 2);
        repeat (2) tick();
        bus.CPU_VRAM_WAs_i = 10'h055;
        bus.CPU_VRAM_WDs_i = 8'h55;
        bus.CPU_VRAM_WE_i  = 1'b1;
        tick();
        SYS_R_i = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        repeat (3) tick();
        SYS_R_i = 1'b0;
        repeat (6) tick();
        chk("rst_no_req_level", 32'(bus.LEVELs_o), 32'd0);
        chk("rst_no_req_busy",  32'(bus.BUSY_o),   32'd0);
        bus.CPU_VRAM_WE_i = 1'b0;
        tick();
        bus.CPU_VRAM_WAs_i = 10'h077;
        bus.CPU_VRAM_WDs_i = 8'h99;
        bus.CPU_VRAM_WE_i  = 1'b1;
        expect_wr(10'h077, 8'h99, cyc + 2);
        tick();
        bus.CPU_VRAM_WE_i = 1'b0;
        repeat (4) tick();
        chk("post_rst_level", 32'(bus.LEVELs_o), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_wr_sched.md
VRAM_WR_SCHED -- requirements
Module: VRAM_WR_SCHED

Interface
REQ-001 The block SHALL have parameter C_DEPTH, default 4, meaning the number of write-queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter C_AW, default 10, meaning the VRAM address width.
REQ-003 The block SHALL have port CK_i, input, 1 bit, the single system clock (NFSC_CK domain); all logic is on its rising edge.
REQ-004 The block SHALL have port SYS_R_i, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port CPU_VRAM_WDs_i, input, 8 bits, CPU write data (register bits).
REQ-006 The block SHALL have port CPU_VRAM_WAs_i, input, C_AW bits, CPU write address.
REQ-007 The block SHALL have port CPU_VRAM_WE_i, input, 1 bit, a CPU write strobe level; each 0->1 edge is one write request.
REQ-008 The block SHALL have port CPU_USE_i, input, 1 bit; when 1, VRAM may be written at any time.
REQ-009 The block SHALL have port BLANK_i, input, 1 bit, the video blanking flag; 1 opens the write window.
REQ-010 The block SHALL have port OVF_CLR_i, input, 1 bit, a one-cycle clear of OVF_o.
REQ-011 The block SHALL have ports VRAM_WDs_o (output, 8 bits), VRAM_WAs_o (output, C_AW bits) and VRAM_WE_o (output, 1 bit), forming the VRAM write port.
REQ-012 The block SHALL have port LEVELs_o, output, log2(C_DEPTH)+1 bits, the current queue occupancy.
REQ-013 The block SHALL have port BUSY_o, output, 1 bit, 1 while the queue is non-empty.
REQ-014 The block SHALL have port OVF_o, output, 1 bit, a sticky flag for a dropped request.

Function
REQ-015 Edge detect: a request SHALL be recognised in cycle n when CPU_VRAM_WE_i is 1 in n and was 0 in n-1; a level held high SHALL yield exactly one request.
REQ-016 A recognised request SHALL push {CPU_VRAM_WAs_i, CPU_VRAM_WDs_i} as sampled in cycle n.
REQ-017 The write window SHALL be WIN = BLANK_i | CPU_USE_i, evaluated every cycle.
REQ-018 The FSM SHALL have three states: IDLE (queue empty), WAIT (non-empty, WIN=0) and DRAIN (non-empty, WIN=1); the state SHALL be recomputed every cycle from next occupancy and WIN.
REQ-019 In DRAIN, one entry SHALL be popped per cycle, oldest first.
REQ-020 A pop in cycle m SHALL drive VRAM_WE_o=1 with the popped address and data in cycle m+1, for exactly one cycle per entry.
REQ-021 VRAM_WAs_o and VRAM_WDs_o SHALL hold their last values while VRAM_WE_o=0.
REQ-022 Latency: a request at cycle n with WIN=1 and an empty queue SHALL be popped at n+1 and appear on VRAM_WE_o at n+2.
REQ-023 There SHALL be no bypass: an entry pushed in cycle n SHALL NOT be popped in cycle n.
REQ-024 When WIN falls, draining SHALL stop after the current cycle; pending entries SHALL be retained in order, and none SHALL be lost or duplicated.
REQ-025 A push and a pop in the same cycle SHALL leave LEVELs_o unchanged, including when the queue is full.
REQ-026 A push while full with no simultaneous pop SHALL be dropped, leave the queue unchanged, and set OVF_o on the next cycle.
REQ-027 OVF_CLR_i SHALL clear OVF_o; a simultaneous new overflow SHALL win, leaving OVF_o=1.
REQ-028 Read and write pointers SHALL wrap modulo C_DEPTH; LEVELs_o SHALL range 0..C_DEPTH.
REQ-029 BUSY_o SHALL equal (LEVELs_o != 0) and SHALL be registered.

Reset
REQ-030 SYS_R_i=1 SHALL asynchronously force the FSM to IDLE, the pointers and LEVELs_o to 0, and VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o, BUSY_o and OVF_o to 0.
REQ-031 The edge-detect history flop SHALL reset to 1, so that a WE level already high at reset release creates no request.
REQ-032 A reset during draining SHALL discard all queued entries; no VRAM_WE_o pulse SHALL follow the reset.

Structure
REQ-033 C_DEPTH, C_AW and the FSM state encodings SHALL live in the shared CHR_GEN package/include, together with the log2 function.
REQ-034 The queue storage and pointers SHALL be one sub-module, VRAM_WR_FIFO (push/pop/full/empty/level); edge detect, FSM and output register SHALL be in VRAM_WR_SCHED.

Verification
REQ-035 Single write: BLANK_i=1, WE 0->1 at cycle 10 with WA=0x123, WD=0x5A -> VRAM_WE_o=1 only at cycle 12 with 0x123/0x5A.
REQ-036 Held window: BLANK_i=0, CPU_USE_i=0, three requests (0x001/0x11, 0x002/0x22, 0x003/0x33) -> no VRAM_WE_o, LEVELs_o=3, BUSY_o=1; then BLANK_i=1 -> three consecutive pulses in order, ending with LEVELs_o=0.
REQ-037 Overflow: window closed, 5 requests with C_DEPTH=4 -> LEVELs_o=4, OVF_o=1, and the 5th entry absent after drain; OVF_CLR_i pulse -> OVF_o=0.
REQ-038 Window chop: 4 entries queued, BLANK_i high for 2 cycles -> exactly 2 writes, LEVELs_o=2, and the remaining 2 written in order at the next blank.
REQ-039 Full push+pop: full queue, WIN=1 and a request in the same cycle -> accepted, LEVELs_o stays 4, OVF_o stays 0.
REQ-040 Reset: SYS_R_i asserted mid-drain with WE held high -> all outputs 0 immediately, and no request after release until WE toggles 0->1.
